// File: rtl/fib_seq_generator.sv
// ---------------------------------------------------------------------------
// fib_seq_generator
//
// Iterative Fibonacci / Lucas term generator. A go strobe, accepted while the
// block is not busy, captures the term index, the sequence select and the
// streaming select. The block then steps a two-term window (a, b) once per
// clock. After n steps, a holds term n, which is registered as the result.
//
// With streaming enabled, every calculation cycle also presents the current
// term on numberOut, qualified by a one-cycle valid pulse. Terms 0..n appear
// in order, and the final pulse lines up with done rising.
//
// Each term carries a sticky overflow flag. Arithmetic wraps modulo
// 2^OUT_W, and the flag records whether the true value has ever exceeded the
// result width. Only term n's flag is reported. The lookahead term b may
// overflow without affecting the result.
//
// Parameters
//   OUT_W      result width in bits, legal range 8..64
//   IDX_W      index width in bits, legal range 1..8
//
// Ports
//   clk        in   1      sole clock, rising edge
//   reset      in   1      asynchronous active-low reset
//   go         in   1      start strobe, ignored while busy
//   numberIn   in   IDX_W  index n of the requested term
//   mode       in   1      0 = Fibonacci (0,1), 1 = Lucas (2,1)
//   stream     in   1      0 = final term only, 1 = emit terms 0..n
//   numberOut  out  OUT_W  result or streamed term
//   valid      out  1      qualifies each streamed term
//   done       out  1      result available, held until the next go
//   busy       out  1      calculation in progress
//   overflow   out  1      term n exceeded 2^OUT_W-1, qualified by done
// ---------------------------------------------------------------------------
module fib_seq_generator #(
    parameter int unsigned OUT_W = 16,
    parameter int unsigned IDX_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go,
    input  logic [IDX_W-1:0] numberIn,
    input  logic             mode,
    input  logic             stream,
    output logic [OUT_W-1:0] numberOut,
    output logic             valid,
    output logic             done,
    output logic             busy,
    output logic             overflow
);

    // Reject parameter values outside the supported range at elaboration.
    if (OUT_W < 8 || OUT_W > 64) begin : g_bad_out_w
        $error("fib_seq_generator: OUT_W must be in 8..64");
    end
    if (IDX_W < 1 || IDX_W > 8) begin : g_bad_idx_w
        $error("fib_seq_generator: IDX_W must be in 1..8");
    end

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StDone
    } state_e;

    state_e           state_q;

    // Captured run parameters.
    logic [IDX_W-1:0] n_q;
    logic             stream_q;

    // Sliding window: a is term cnt, b is term cnt+1.
    logic [OUT_W-1:0] a_q;
    logic [OUT_W-1:0] b_q;
    logic             a_ovf_q;
    logic             b_ovf_q;
    logic [IDX_W-1:0] cnt_q;

    // One extra bit captures the carry out of the modular add.
    logic [OUT_W:0]   sum;
    logic [OUT_W-1:0] seed0;

    always_comb begin
        sum   = {1'b0, a_q} + {1'b0, b_q};
        seed0 = mode ? OUT_W'(2) : '0;
    end

    assign busy = (state_q == StCalc);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            n_q       <= '0;
            stream_q  <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            a_ovf_q   <= 1'b0;
            b_ovf_q   <= 1'b0;
            cnt_q     <= '0;
            numberOut <= '0;
            valid     <= 1'b0;
            done      <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            case (state_q)
                StIdle, StDone: begin
                    // valid is a single-cycle pulse and never survives the calc phase.
                    valid <= 1'b0;
                    if (go) begin
                        n_q      <= numberIn;
                        stream_q <= stream;
                        a_q      <= seed0;
                        b_q      <= OUT_W'(1);
                        a_ovf_q  <= 1'b0;
                        b_ovf_q  <= 1'b0;
                        cnt_q    <= '0;
                        done     <= 1'b0;
                        overflow <= 1'b0;
                        state_q  <= StCalc;
                    end
                end

                StCalc: begin
                    // go is deliberately ignored here; runs are not restartable mid-flight.
                    if (stream_q) begin
                        numberOut <= a_q;
                        valid     <= 1'b1;
                    end else begin
                        valid     <= 1'b0;
                    end

                    if (cnt_q == n_q) begin
                        numberOut <= a_q;
                        overflow  <= a_ovf_q;
                        done      <= 1'b1;
                        state_q   <= StDone;
                    end else begin
                        a_q     <= b_q;
                        a_ovf_q <= b_ovf_q;
                        b_q     <= sum[OUT_W-1:0];
                        // Sticky: once any predecessor overflowed, the true sum exceeds the width too.
                        b_ovf_q <= a_ovf_q | b_ovf_q | sum[OUT_W];
                        cnt_q   <= cnt_q + 1'b1;
                    end
                end

                default: begin
                    state_q <= StIdle;
                    valid   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fib_seq_generator.sv
// Directed bench for fib_seq_generator with OUT_W=16, IDX_W=5.
module tb_fib_seq_generator;

    localparam int unsigned OUT_W = 16;
    localparam int unsigned IDX_W = 5;

    logic             clk;
    logic             reset;
    logic             go;
    logic [IDX_W-1:0] numberIn;
    logic             mode;
    logic             stream;
    logic [OUT_W-1:0] numberOut;
    logic             valid;
    logic             done;
    logic             busy;
    logic             overflow;

    int errors = 0;
    int checks = 0;
    logic [OUT_W-1:0] streamed[$];

    fib_seq_generator #(
        .OUT_W(OUT_W),
        .IDX_W(IDX_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .go       (go),
        .numberIn (numberIn),
        .mode     (mode),
        .stream   (stream),
        .numberOut(numberOut),
        .valid    (valid),
        .done     (done),
        .busy     (busy),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Launches one run and waits, with a cycle bound, for done.
    // Checks latency, result, overflow and the post-done behaviour.
    task automatic run(input int n, input bit md, input bit st, input bit hold_go,
                       input logic [OUT_W-1:0] exp_val, input bit exp_ovf, input string tag);
        int edges;
        logic [OUT_W-1:0] held;
        streamed.delete();
        @(negedge clk);
        numberIn = IDX_W'(n);
        mode     = md;
        stream   = st;
        go       = 1'b1;
        @(posedge clk);
        #1;
        check({tag, "_busy"}, 64'(busy), 64'd1);
        check({tag, "_done_low"}, 64'(done), 64'd0);
        // Scramble the captured inputs; they must be don't-care from here on.
        numberIn = ~numberIn;
        mode     = ~mode;
        stream   = ~stream;
        if (!hold_go) go = 1'b0;
        edges = 0;
        while (!done && edges < 100) begin
            @(posedge clk);
            #1;
            edges++;
            if (valid) streamed.push_back(numberOut);
            // Drop go before the edge after done so a held go cannot restart.
            if (done) go = 1'b0;
        end
        go = 1'b0;
        check({tag, "_latency"}, 64'(edges), 64'(n + 1));
        check({tag, "_value"}, 64'(numberOut), 64'(exp_val));
        check({tag, "_ovf"}, 64'(overflow), 64'(exp_ovf));
        check({tag, "_busy_end"}, 64'(busy), 64'd0);
        check({tag, "_valid_at_done"}, 64'(valid), 64'(st));
        held = numberOut;
        @(posedge clk);
        #1;
        check({tag, "_valid_drop"}, 64'(valid), 64'd0);
        check({tag, "_done_hold"}, 64'(done), 64'd1);
        check({tag, "_value_hold"}, 64'(numberOut), 64'(held));
    endtask

    initial begin
        logic [OUT_W-1:0] exp_stream[6];
        int cyc;
        bit saw;
        exp_stream = '{16'd0, 16'd1, 16'd1, 16'd2, 16'd3, 16'd5};

        reset    = 1'b0;
        go       = 1'b1;  // go during reset must be ignored
        numberIn = '0;
        mode     = 1'b0;
        stream   = 1'b0;
        #1;
        check("rst_out", 64'(numberOut), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_valid", 64'(valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_ovf", 64'(overflow), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_go_ignored", 64'(busy), 64'd0);
        @(negedge clk);
        go    = 1'b0;
        reset = 1'b1;

        // Fibonacci term 6, final result only.
        run(6, 1'b0, 1'b0, 1'b0, 16'd8, 1'b0, "fib6");

        // Abort a run with an asynchronous mid-cycle reset.
        @(negedge clk);
        numberIn = 5'd10;
        mode     = 1'b0;
        stream   = 1'b0;
        go       = 1'b1;
        @(posedge clk);
        #1;
        go = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        reset = 1'b0;
        go    = 1'b1;
        #1;
        check("abort_out", 64'(numberOut), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_valid", 64'(valid), 64'd0);
        check("abort_ovf", 64'(overflow), 64'd0);
        @(negedge clk);
        go    = 1'b0;
        reset = 1'b1;
        saw   = 1'b0;
        for (cyc = 0; cyc < 15; cyc++) begin
            @(posedge clk);
            #1;
            if (done || valid || busy) saw = 1'b1;
        end
        check("abort_quiet", 64'(saw), 64'd0);
        run(10, 1'b0, 1'b0, 1'b0, 16'd55, 1'b0, "fib10");

        // Boundary terms: 24 fits, and term 25 wraps.
        run(24, 1'b0, 1'b0, 1'b0, 16'd46368, 1'b0, "fib24");
        run(25, 1'b0, 1'b0, 1'b0, 16'd9489, 1'b1, "fib25");

        // Lucas sequence.
        run(10, 1'b1, 1'b0, 1'b0, 16'd123, 1'b0, "luc10");

        // Streaming with go held high throughout the calculation.
        run(5, 1'b0, 1'b1, 1'b1, 16'd5, 1'b0, "stream5");
        check("stream5_count", 64'(streamed.size()), 64'd6);
        for (int i = 0; i < 6; i++) begin
            if (i < streamed.size())
                check($sformatf("stream5_term%0d", i), 64'(streamed[i]), 64'(exp_stream[i]));
            else
                check($sformatf("stream5_term%0d_missing", i), 64'd1, 64'd0);
        end

        // n=0 on the Lucas sequence returns the seed after one edge.
        run(0, 1'b1, 1'b0, 1'b0, 16'd2, 1'b0, "luc0");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fib_seq_generator.md
FIB_SEQ_GENERATOR -- requirements
Module: fib_seq_generator

Interface
REQ-001 Parameter OUT_W, default 16, is the result width in bits; the legal range SHALL be 8..64.
REQ-002 Parameter IDX_W, default 5, is the sequence-index width in bits; the legal range SHALL be 1..8.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; reset=0 SHALL clear all state immediately.
REQ-005 go  input  1  start strobe, sampled on the rising edge of clk.
REQ-006 numberIn  input  IDX_W  index n of the term to compute, captured when go is accepted.
REQ-007 mode  input  1  selects the sequence: 0 = Fibonacci (seed 0,1), 1 = Lucas (seed 2,1); captured when go is accepted.
REQ-008 stream  input  1  0 = report the final term only, 1 = emit every term 0..n; captured when go is accepted.
REQ-009 numberOut  output  OUT_W  registered result or streamed term.
REQ-010 valid  output  1  registered one-cycle strobe qualifying each streamed term.
REQ-011 done  output  1  registered; high when the final result is available.
REQ-012 busy  output  1  high while in state CALC.
REQ-013 overflow  output  1  high when term n exceeds 2^OUT_W-1; qualified by done.

Function
REQ-014 The FSM SHALL have three states: IDLE, CALC and DONE; busy = (state==CALC).
REQ-015 In IDLE or DONE, go=1 SHALL be accepted on that edge, with the following actions:
- capture n, mode and stream;
- a<=seed0 and b<=1;
- a_ovf<=0 and b_ovf<=0;
- cnt<=0, done<=0, valid<=0;
- state<=CALC.
REQ-016 In CALC, go SHALL be ignored.
REQ-017 In each CALC cycle with cnt<n, the block SHALL perform:
- a<=b, a_ovf<=b_ovf;
- b<=(a+b) mod 2^OUT_W;
- b_ovf<=a_ovf|b_ovf|carry-out of a+b;
- cnt<=cnt+1.
REQ-018 In the CALC cycle with cnt==n, the block SHALL perform:
- numberOut<=a, overflow<=a_ovf;
- done<=1, state<=DONE.
REQ-019 Latency: with go accepted at edge k, done SHALL rise at edge k+n+1; for n=0 this is edge k+1 and numberOut = seed0.
REQ-020 When stream=1, every CALC cycle SHALL register numberOut<=a and valid<=1, giving n+1 valid pulses carrying terms 0..n in order; the last pulse SHALL coincide with done rising.
REQ-021 When stream=0, valid SHALL stay 0 and numberOut SHALL change only at the done edge.
REQ-022 valid SHALL return to 0 on the cycle after the done edge.
REQ-023 In DONE, done, numberOut and overflow SHALL hold until the next accepted go; done and overflow SHALL drop on that go edge.
REQ-024 On overflow, numberOut SHALL carry the true value mod 2^OUT_W.
REQ-025 overflow SHALL reflect term n only; overflow in the lookahead term n+1 SHALL NOT set it.
REQ-026 Once set, overflow SHALL persist for all later streamed terms of the same run.
REQ-027 mode, stream and numberIn SHALL be don't-care except on the edge where go is accepted.

Reset
REQ-028 On reset=0, asynchronously and independent of clk, the block SHALL set:
- state=IDLE;
- numberOut=0, done=0, valid=0, busy=0, overflow=0;
- a, b, cnt and the overflow flags to 0.
REQ-029 A reset during CALC SHALL abort the run; no done or valid SHALL follow it.
REQ-030 go asserted during reset SHALL be ignored.
REQ-031 The first go accepted after reset releases SHALL behave per REQ-015.

Verification (OUT_W=16, IDX_W=5)
REQ-032 go, n=6, mode=0, stream=0 -> done rises 7 edges after go; numberOut=8; overflow=0.
REQ-033 go, n=10, then reset low for one cycle 3 cycles later -> all outputs 0, no done; a following go with n=10 -> numberOut=55.
REQ-034 go, n=24, mode=0 -> numberOut=46368, overflow=0. Then go, n=25 -> numberOut=9489, overflow=1.
REQ-035 go, n=10, mode=1 -> numberOut=123.
REQ-036 go, n=5, mode=0, stream=1 -> six valid pulses carrying 0,1,1,2,3,5; done coincides with the 5; go held high during CALC has no effect.
REQ-037 go, n=0, mode=1 -> done at the first edge after go; numberOut=2.
